// File: rtl/wb_commit_pkg.sv
// Shared types for the writeback commit stage and its trace FIFO.
// Holds the register-write bundle, trace record layout and select codes.
package wb_commit_pkg;

    typedef struct packed {
        logic RFWr;
        logic HIWr;
        logic LOWr;
    } RegsWrType;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } TraceEntry;

    localparam logic [1:0] WBSEL_RESULT = 2'b00;
    localparam logic [1:0] WBSEL_DMOUT  = 2'b01;

    localparam int TRACE_DEPTH_DEF = 4;

    function automatic logic [3:0] trace_wen(input logic wr);
        return wr ? 4'hF : 4'h0;
    endfunction

endpackage

// File: rtl/wb_commit_trace_fifo.sv
// First-word-fall-through FIFO of commit trace records.
// Head is registered: a push is visible at dout no earlier than next cycle.
module trace_fifo
    import wb_commit_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  TraceEntry                din,
    input  logic                     pop,
    output TraceEntry                dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    TraceEntry       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/wb_commit.sv
// Writeback commit: selects write data, gates RF writes on trace space,
// stalls when the trace FIFO is full and counts committed instructions.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int TRACE_DEPTH = TRACE_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] WB_PC,
    input  logic [31:0] WB_Instr,
    input  logic [1:0]  WB_WbSel,
    input  logic [4:0]  WB_Dst,
    input  logic [31:0] WB_DMOut,
    input  logic [31:0] WB_Result,
    input  RegsWrType   WB_RegsWrType,
    output logic        RF_Wen,
    output logic [4:0]  RF_Waddr,
    output logic [31:0] RF_Wdata,
    output logic        WB_Stall,
    output logic        debug_wb_valid,
    input  logic        debug_wb_ready,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic [31:0] commit_cnt
);

    localparam int CW = $clog2(TRACE_DEPTH) + 1;

    logic          valid;
    logic          wr;
    logic [31:0]   wdata;
    logic          full;
    logic          pop;
    logic          accept;
    logic [CW-1:0] fifo_count;
    logic [31:0]   commit_q;
    TraceEntry     entry;
    TraceEntry     head;
    logic          unused;

    assign unused = ^{WB_Instr, WB_RegsWrType.HIWr, WB_RegsWrType.LOWr};

    assign valid = (WB_PC != 32'b0);
    assign wdata = (WB_WbSel == WBSEL_DMOUT) ? WB_DMOut : WB_Result;
    assign wr    = valid & WB_RegsWrType.RFWr & (WB_Dst != 5'd0);

    assign full   = (fifo_count == CW'(TRACE_DEPTH));
    assign pop    = debug_wb_valid & debug_wb_ready;
    // A pop at full frees the slot in the same edge, so no stall.
    assign accept = valid & (~full | pop);

    assign RF_Wen   = wr & accept & rst;
    assign RF_Waddr = WB_Dst;
    assign RF_Wdata = wdata;
    assign WB_Stall = valid & ~accept & rst;

    assign entry.pc    = WB_PC;
    assign entry.wen   = trace_wen(wr);
    assign entry.wnum  = WB_Dst;
    assign entry.wdata = wdata;

    trace_fifo #(
        .DEPTH (TRACE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (entry),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count)
    );

    assign debug_wb_valid    = (fifo_count != '0);
    assign debug_wb_pc       = head.pc;
    assign debug_wb_rf_wen   = head.wen;
    assign debug_wb_rf_wnum  = head.wnum;
    assign debug_wb_rf_wdata = head.wdata;

    always_ff @(posedge clk) begin
        if (!rst)        commit_q <= '0;
        else if (accept) commit_q <= commit_q + 32'd1;
    end

    assign commit_cnt = commit_q;

endmodule
